// File: rtl/sram_ctrl_if.sv
// SRAM request/acknowledge bus between a bus master and sram_ctrl.
interface sram_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_rd;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output addr, wr_data, wr_rd, valid,
    input  ready, rd_data
  );

  modport slave (
    input  addr, wr_data, wr_rd, valid,
    output ready, rd_data
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: one outstanding request, fixed write/read
// latency, one-cycle ready pulse on completion.
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | latency down-counter running
// RESP  | ready high for one cycle
module sram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int WR_LAT = 1,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus
);

  if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
    $error("sram_ctrl: WR_LAT must be in 1..15");
  end
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("sram_ctrl: RD_LAT must be in 1..15");
  end

  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              capture;
  logic              commit;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              ready_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Next-state, counter and strobe decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid) begin
          capture   = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = bus.wr_rd ? WR_LOAD : RD_LOAD;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // valid seen here still belongs to the completing transaction
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and request holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wr_data;
        wr_q    <= bus.wr_rd;
      end
    end
  end

  // Registered ready pulse and read data; rd_data moves only on read completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ready_q <= commit;
      if (commit && !wr_q) begin
        rd_data_q <= mem[addr_q];
      end
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && wr_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: scoreboarded random/directed traffic on a default
// instance, plus a WR_LAT=4 instance for the reset-during-write case.
module tb_sram_ctrl;

  localparam int WL  = 1;
  localparam int RL  = 2;
  localparam int WL4 = 4;
  localparam int RL4 = 3;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  longint cyc = 0;

  always #5 clk = ~clk;

  // Count of rising edges; read at negedges.
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus  ();
  sram_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus4 ();

  sram_ctrl #(.ADDR_W(8), .DATA_W(16), .WR_LAT(WL), .RD_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sram_ctrl #(.ADDR_W(8), .DATA_W(16), .WR_LAT(WL4), .RD_LAT(RL4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word-level memory plus queue of expected completions.
  typedef struct {
    bit          rd;
    logic [15:0] data;
    longint      due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [int];
  logic [15:0] last_rd = 16'h0000;
  bit          prev_ready = 1'b0;

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.ready) begin
        check("ready_not_back_to_back", prev_ready, 1'b0);
        if (sb.size() == 0) begin
          check("ready_without_request", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("ready_cycle", cyc, e.due);
          if (e.rd) begin
            check("rd_data", bus.rd_data, e.data);
            last_rd = e.data;
          end else begin
            check("rd_data_hold_on_write", bus.rd_data, last_rd);
          end
        end
      end
      prev_ready = bus.ready;
    end
  end

  // One request on the default instance; valid left high for back-to-back.
  task automatic txn(input bit wr, input logic [7:0] a, input logic [15:0] d, input bit scramble);
    longint acc;
    exp_t   e;
    int     n;
    @(negedge clk);
    bus.valid   = 1'b1;
    bus.wr_rd   = wr;
    bus.addr    = a;
    bus.wr_data = d;
    acc = cyc + 1;
    if (wr) begin
      ref_mem[int'(a)] = d;
      e = '{rd: 1'b0, data: d, due: acc + WL};
    end else begin
      e = '{rd: 1'b1, data: ref_mem[int'(a)], due: acc + RL};
    end
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && !bus.ready) begin
        bus.addr    = 8'($urandom);
        bus.wr_data = 16'($urandom);
      end
    end while (!bus.ready && n < 50);
    if (!bus.ready) begin
      check("ready_timeout", 1'b0, 1'b1);
      sb.delete();
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One request on the WR_LAT=4 instance, with its latency checked directly.
  task automatic op4(input bit wr, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd);
    int n;
    @(negedge clk);
    bus4.valid   = 1'b1;
    bus4.wr_rd   = wr;
    bus4.addr    = a;
    bus4.wr_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus4.ready && n < 50);
    check(wr ? "lat4_write_latency" : "lat4_read_latency", n, wr ? WL4 + 1 : RL4 + 1);
    if (!wr) check("lat4_rd_data", bus4.rd_data, exp_rd);
    @(negedge clk);
    bus4.valid = 1'b0;
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] a;
    bit         seen;

    rst  = 1'b0;
    rst4 = 1'b0;
    bus.valid   = 1'b1;
    bus.wr_rd   = 1'b1;
    bus.addr    = 8'h55;
    bus.wr_data = 16'hDEAD;
    bus4.valid   = 1'b0;
    bus4.wr_rd   = 1'b0;
    bus4.addr    = 8'h00;
    bus4.wr_data = 16'h0000;

    // Reset held with valid asserted: nothing may happen.
    repeat (3) begin
      @(negedge clk);
      check("reset_ready", bus.ready, 1'b0);
      check("reset_rd_data", bus.rd_data, 16'h0000);
    end
    bus.valid = 1'b0;
    rst  = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle_ready", bus.ready, 1'b0);

    // Write then read, back to back.
    txn(1'b1, 8'h3C, 16'hA55A, 1'b0);
    txn(1'b0, 8'h3C, 16'h0000, 1'b0);
    idle(2);

    // Back-to-back reads of 8'h00 and 8'hFF.
    txn(1'b1, 8'h00, 16'h1111, 1'b0);
    txn(1'b1, 8'hFF, 16'hFFFF, 1'b0);
    idle(1);
    txn(1'b0, 8'h00, 16'h0000, 1'b0);
    txn(1'b0, 8'hFF, 16'h0000, 1'b0);
    idle(2);

    // Inputs changed while busy must not affect the write.
    txn(1'b1, 8'h10, 16'h5678, 1'b1);
    idle(1);
    txn(1'b0, 8'h10, 16'h0000, 1'b0);
    idle(2);

    // Address extremes do not alias.
    txn(1'b1, 8'hFF, 16'h0F0F, 1'b0);
    txn(1'b1, 8'h00, 16'hF0F0, 1'b0);
    txn(1'b0, 8'hFF, 16'h0000, 1'b0);
    txn(1'b0, 8'h00, 16'h0000, 1'b0);
    idle(2);

    // Random traffic over a small address pool; reads only of written words.
    pool = '{8'h00, 8'h01, 8'h3C, 8'h7F, 8'h80, 8'hA5, 8'hFE, 8'hFF};
    for (int i = 0; i < 60; i++) begin
      a = pool[$urandom_range(0, 7)];
      if (ref_mem.exists(int'(a)) && $urandom_range(0, 1) == 1)
        txn(1'b0, a, 16'h0000, 1'($urandom_range(0, 1)));
      else
        txn(1'b1, a, 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    idle(4);
    check("scoreboard_drained", sb.size(), 0);

    // Reset in the middle of a WR_LAT=4 write.
    op4(1'b1, 8'h20, 16'h0123, 16'h0000);
    @(negedge clk);
    bus4.valid   = 1'b1;
    bus4.wr_rd   = 1'b1;
    bus4.addr    = 8'h20;
    bus4.wr_data = 16'hBEEF;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    bus4.valid = 1'b0;
    seen = bus4.ready;
    repeat (2) begin
      @(negedge clk);
      seen = seen | bus4.ready;
    end
    check("lat4_reset_rd_data", bus4.rd_data, 16'h0000);
    rst4 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus4.ready;
    end
    check("lat4_no_ready_after_reset", seen, 1'b0);
    op4(1'b0, 8'h20, 16'h0000, 16'h0123);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
